// File: rtl/otter_csr_pkg.sv
// Shared constants, CSR opcode enum and the CSR write-op helper for the OTTER
// machine-mode CSR / interrupt block.
package otter_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        CSRRW = 3'b001,
        CSRRS = 3'b010,
        CSRRC = 3'b011
    } csr_op_t;

    localparam logic [31:0] MCAUSE_EXT_INT   = 32'h8000_000B;
    localparam int          MSTATUS_MIE_BIT  = 3;
    localparam int          MSTATUS_MPIE_BIT = 7;

    // Value a CSR takes after a CSRRW/CSRRS/CSRRC given its current value.
    function automatic logic [31:0] csr_alu(csr_op_t op, logic [31:0] old, logic [31:0] src);
        logic [31:0] res;
        case (op)
            CSRRW:   res = src;
            CSRRS:   res = old | src;
            CSRRC:   res = old & ~src;
            default: res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// External interrupt synchroniser with registered edge detect and a sticky
// pending latch (or a plain level follower when EDGE_TRIG=0).
module intr_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic INTR,
    input  logic clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, one-cycle delayed copy and registered rising-edge flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], INTR};
            dly_q  <= sync_lvl;
            edge_q <= sync_lvl & ~dly_q;
        end
    end

    // Pending next state: a fresh edge beats a clear in the same cycle.
    always_comb begin
        pend_d = pend_q;
        if (EDGE_TRIG) begin
            if (edge_q)   pend_d = 1'b1;
            else if (clr) pend_d = 1'b0;
        end else begin
            pend_d = dly_q;
        end
    end

    // Pending latch register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end

    assign pending = pend_q;

endmodule

// File: rtl/otter_csr_intr_ctrl.sv
// Machine-mode CSR file (mstatus/mtvec/mepc/mcause) and external interrupt
// gating for the OTTER multicycle core. Sequencing is owned by CU_FSM.
module otter_csr_intr_ctrl
    import otter_csr_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter bit          EDGE_TRIG   = 1'b1,
    parameter logic [31:0] MTVEC_RST   = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INTR,
    input  logic [11:0] csr_addr,
    input  logic [2:0]  csr_funct3,
    input  logic        csr_WE,
    input  logic [31:0] rs1,
    input  logic [31:0] PC,
    input  logic        int_taken,
    input  logic        mret_exec,
    output logic        intr_pend,
    output logic [31:0] csr_RD,
    output logic [31:0] MTVEC,
    output logic [31:0] MEPC
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] mstatus_rd, wdata;
    logic        wr_en, mret_go, pending;

    intr_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TRIG  (EDGE_TRIG)
    ) u_sync (
        .CLK    (CLK),
        .RST    (RST),
        .INTR   (INTR),
        .clr    (int_taken),
        .pending(pending)
    );

    // Read mux: always the pre-write value so rd and the CSR update share an edge.
    always_comb begin
        mstatus_rd                   = 32'h0;
        mstatus_rd[MSTATUS_MIE_BIT]  = mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mpie_q;
        case (csr_addr)
            CSR_MSTATUS: csr_RD = mstatus_rd;
            CSR_MTVEC:   csr_RD = mtvec_q;
            CSR_MEPC:    csr_RD = mepc_q;
            CSR_MCAUSE:  csr_RD = mcause_q;
            default:     csr_RD = 32'h0;
        endcase
    end

    // Write qualification and write-op ALU.
    always_comb begin
        case (csr_funct3)
            CSRRW, CSRRS, CSRRC: wr_en = csr_WE;
            default:             wr_en = 1'b0;
        endcase
        wdata   = csr_alu(csr_op_t'(csr_funct3), csr_RD, rs1);
        mret_go = mret_exec & ~int_taken;
    end

    // Next-state: CSR write first, then trap/return overrides the fields they own,
    // which drops any overlapping software write to those fields.
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = wdata[MSTATUS_MIE_BIT];
                    mpie_d = wdata[MSTATUS_MPIE_BIT];
                end
                CSR_MTVEC:  mtvec_d  = wdata & ~32'h3;
                CSR_MEPC:   mepc_d   = wdata & ~32'h3;
                CSR_MCAUSE: mcause_d = wdata;
                default: ;
            endcase
        end
        if (int_taken) begin
            mepc_d   = PC & ~32'h3;
            mcause_d = MCAUSE_EXT_INT;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_go) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    // CSR state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtvec_q  <= MTVEC_RST & ~32'h3;
            mepc_q   <= 32'h0;
            mcause_q <= 32'h0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    assign intr_pend = pending & mie_q;
    assign MTVEC     = mtvec_q;
    assign MEPC      = mepc_q;

endmodule
